// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin sharing of one 16-bit serializer among N_REQ requesters
module serializer_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int START_TO = 3
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req_val,
  input  logic [N_REQ*16-1:0]  i_req_data,
  input  logic [N_REQ*4-1:0]   i_req_mod,
  output logic [N_REQ-1:0]     o_req_rdy,
  output logic [15:0]          o_ser_data,
  output logic [3:0]           o_ser_mod,
  output logic                 o_ser_val,
  input  logic                 i_ser_busy,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_done,
  output logic                 o_err,
  output logic [ID_W-1:0]      o_err_id,
  output logic                 o_active
);
  localparam int CW = $clog2(START_TO + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ID_W-1:0] ptr, win, idx;
  logic [3:0] win_mod;
  logic found, hs, bad, tmo;
  // first asserted request at or after the pointer, wrapping
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && i_req_val[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign hs        = state == IDLE && !i_ser_busy && found;
  assign o_req_rdy = hs ? N_REQ'(1) << win : '0;
  assign win_mod   = i_req_mod[{win, 2'b00} +: 4];
  assign bad       = win_mod == 4'd1 || win_mod == 4'd2;
  assign tmo       = state == WAIT_START && !i_ser_busy && cnt == CW'(START_TO - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = hs && !bad ? LAUNCH : IDLE;
      LAUNCH:     state_nx = WAIT_START;
      WAIT_START: state_nx = i_ser_busy ? WAIT_DONE : tmo ? IDLE : WAIT_START;
      WAIT_DONE:  state_nx = i_ser_busy ? WAIT_DONE : IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      o_ser_data <= '0;
      o_ser_mod  <= '0;
      o_ser_val  <= 1'b0;
      o_grant_id <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_id   <= '0;
      o_active   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= state == WAIT_START ? cnt + 1'b1 : '0;
      o_ser_val <= state_nx == LAUNCH;
      o_active  <= state_nx != IDLE;
      o_done    <= state == WAIT_DONE && !i_ser_busy;
      o_err     <= (hs && bad) || tmo;
      if (hs) begin
        ptr        <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
        o_ser_data <= i_req_data[{win, 4'b0000} +: 16];
        o_ser_mod  <= win_mod;
        o_grant_id <= win;
      end
      if (hs && bad) o_err_id <= win;
      else if (tmo) o_err_id <= o_grant_id;
    end
  end
endmodule

// File: tb/tb_serializer_arbiter.sv
// tb_serializer_arbiter: scoreboard bench with a simple serializer busy model
module tb_serializer_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n, busy, ext_busy = 1'b0, ser_en = 1'b1;
  logic [N-1:0] val = '0;
  logic [N*16-1:0] data = '0;
  logic [N*4-1:0] mod = '0;
  logic [N-1:0] rdy;
  logic [15:0] ser_data;
  logic [3:0] ser_mod;
  logic ser_val, done, err, active;
  logic [1:0] grant_id, err_id;
  int n_chk = 0, n_err = 0, cyc = 0, n_val = 0, n_done = 0, bcnt = 0;
  int ref_ptr = 0;
  typedef struct {int id; logic [15:0] d; logic [3:0] m;} item_t;
  item_t q[$];
  int eq[$];
  item_t cur;
  bit cur_v = 0;
  serializer_arbiter #(.N_REQ(N), .ID_W(2), .START_TO(3)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_req_val(val), .i_req_data(data), .i_req_mod(mod),
    .o_req_rdy(rdy), .o_ser_data(ser_data), .o_ser_mod(ser_mod), .o_ser_val(ser_val),
    .i_ser_busy(busy), .o_grant_id(grant_id), .o_done(done), .o_err(err),
    .o_err_id(err_id), .o_active(active)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // serializer goes busy the cycle after a load, for mod cycles (0 means 16)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (ser_val && ser_en) bcnt <= ser_mod == 0 ? 16 : int'(ser_mod);
    else if (bcnt > 0) bcnt <= bcnt - 1;
  assign busy = bcnt != 0 || ext_busy;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin : mon
    int e;
    item_t it;
    if (!rst_n) begin
      ref_ptr = 0;
      q.delete();
      eq.delete();
      cur_v = 0;
    end else begin
      if (rdy != 0) begin
        e = -1;
        for (int i = 0; i < N; i++) if (e < 0 && val[(ref_ptr + i) % N]) e = (ref_ptr + i) % N;
        chk("grant", rdy, e < 0 ? 0 : 1 << e);
        if (e >= 0) begin
          ref_ptr = (e + 1) % N;
          it.id = e;
          it.d = data[16*e +: 16];
          it.m = mod[4*e +: 4];
          if (it.m == 1 || it.m == 2) eq.push_back(e);
          else q.push_back(it);
        end
      end
      if (ser_val) begin
        n_val++;
        if (q.size() == 0) chk("unexp_val", ser_val, 0);
        else begin
          cur = q.pop_front();
          cur_v = 1;
          chk("ser_data", ser_data, cur.d);
          chk("ser_mod", ser_mod, cur.m);
        end
      end
      if (done) begin
        n_done++;
        if (!cur_v) chk("unexp_done", done, 0);
        else begin
          chk("done_id", grant_id, cur.id);
          cur_v = 0;
        end
      end
      if (err) begin
        if (eq.size() > 0) chk("err_id", err_id, eq.pop_front());
        else if (cur_v) begin
          chk("to_id", err_id, cur.id);
          cur_v = 0;
        end else chk("unexp_err", err, 0);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_sig(input bit sel_done, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      smp;
      if (sel_done ? done : rdy != 0) at = cyc;
    end
    chk(sel_done ? "wait_done" : "wait_rdy", at >= 0, 1);
  endtask
  task automatic do_reset;
    tick;
    rst_n = 1'b0;
    val = '0;
    ext_busy = 1'b0;
    ser_en = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int at, t0, bd, bv;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick;
    smp;
    chk("rst_outs", {ser_data, ser_mod, ser_val, done, err, active, grant_id, err_id}, 0);
    tick;
    rst_n = 1'b1;
    // single 16-bit transfer
    tick;
    data[15:0] = 16'hA5C3;
    mod[3:0] = 4'd0;
    val[0] = 1'b1;
    smp;
    chk("t1_rdy", rdy, 1);
    t0 = cyc;
    tick;
    val[0] = 1'b0;
    smp;
    chk("t1_val", ser_val, 1);
    chk("t1_data", ser_data, 16'hA5C3);
    chk("t1_active", active, 1);
    bd = n_done;
    wait_sig(1, 40, at);
    chk("t1_lat", at - t0, 19);
    repeat (3) smp;
    chk("t1_once", n_done - bd, 1);
    chk("t1_hold", ser_data, 16'hA5C3);
    chk("t1_inactive", active, 0);
    // round robin with all four held
    do_reset;
    for (int k = 0; k < N; k++) begin
      data[16*k +: 16] = 16'h1000 * (k + 1);
      mod[4*k +: 4] = 4'd4;
    end
    val = 4'hf;
    bd = n_done;
    for (int g = 0; g < 5; g++) begin
      wait_sig(0, 40, at);
      chk("t2_order", rdy, 1 << (g % N));
      chk("t2_done_before", n_done - bd, g);
      tick;
      data[16*(g%N) +: 16] = data[16*(g%N) +: 16] + 16'd1;
    end
    val = '0;
    wait_sig(1, 40, at);
    chk("t2_dones", n_done - bd, 5);
    // illegal mod followed by a pending legal request
    do_reset;
    data[47:32] = 16'h2222;
    mod[11:8] = 4'd1;
    data[63:48] = 16'h3333;
    mod[15:12] = 4'd5;
    val = 4'b1100;
    bv = n_val;
    wait_sig(0, 10, at);
    chk("t3_rdy2", rdy, 4);
    tick;
    val[2] = 1'b0;
    smp;
    chk("t3_err", err, 1);
    chk("t3_err_id", err_id, 2);
    chk("t3_noval", ser_val, 0);
    chk("t3_rdy3", rdy, 8);
    tick;
    val[3] = 1'b0;
    wait_sig(1, 30, at);
    chk("t3_nval", n_val - bv, 1);
    // start timeout with a dead serializer
    do_reset;
    ser_en = 1'b0;
    data[31:16] = 16'hBEEF;
    mod[7:4] = 4'd8;
    val = 4'b0010;
    bd = n_done;
    wait_sig(0, 10, at);
    chk("t4_rdy", rdy, 2);
    tick;
    val = '0;
    for (int i = 1; i <= 8; i++) begin
      smp;
      chk("t4_val", ser_val, i == 1);
      chk("t4_err", err, i == 5);
      if (i == 5) chk("t4_err_id", err_id, 1);
    end
    chk("t4_no_done", n_done - bd, 0);
    ser_en = 1'b1;
    tick;
    mod[11:8] = 4'd4;
    val = 4'b0100;
    smp;
    chk("t4_idle", rdy, 4);
    tick;
    val = '0;
    wait_sig(1, 30, at);
    // reset during WAIT_DONE
    do_reset;
    data[15:0] = 16'h5A5A;
    mod[3:0] = 4'd0;
    mod[7:4] = 4'd3;
    val = 4'b0001;
    wait_sig(0, 10, at);
    tick;
    val = '0;
    bd = n_done;
    repeat (8) smp;
    chk("t5_active", active, 1);
    #1 rst_n = 1'b0;
    #1 chk("t5_rst_outs", {ser_data, ser_mod, ser_val, done, err, active, grant_id, err_id}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (25) smp;
    chk("t5_no_done", n_done - bd, 0);
    tick;
    val = 4'b0011;
    smp;
    chk("t5_ptr", rdy, 1);
    tick;
    val = '0;
    wait_sig(1, 40, at);
    // external busy blocks arbitration
    do_reset;
    ext_busy = 1'b1;
    mod[3:0] = 4'd4;
    val = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("t6_blocked", rdy, 0);
    end
    tick;
    ext_busy = 1'b0;
    smp;
    chk("t6_rdy", rdy, 1);
    tick;
    val = '0;
    wait_sig(1, 30, at);
    repeat (2) tick;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
- Shares one 16-bit serializer between N_REQ requesters.
- Per-requester valid/ready handshake; round-robin grant; drives the serializer load interface (data, mod, one-cycle val).
- Monitors serializer busy to sequence one transfer at a time.
- Rejects illegal length codes (mod 1, 2) and flags them, plus a start-timeout error if the serializer never goes busy.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-id width, equal to clog2(N_REQ).
- START_TO, 3, cycles to wait for serializer busy after launch before flagging error.

Ports:
- clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_val  input  N_REQ  per-requester request valid.
- i_req_data  input  N_REQ*16  request data; requester k occupies bits [16k+15:16k].
- i_req_mod  input  N_REQ*4  length code; requester k occupies bits [4k+3:4k]. 0 means 16 bits; 3..15 mean that many MSB-first bits; 1 and 2 are illegal.
- o_req_rdy  output  N_REQ  one-hot accept strobe.
- o_ser_data  output  16  serializer data.
- o_ser_mod  output  4  serializer length code.
- o_ser_val  output  1  serializer load strobe, one cycle wide.
- i_ser_busy  input  1  serializer busy flag.
- o_grant_id  output  ID_W  id of the requester currently owning the serializer.
- o_done  output  1  one-cycle pulse when a transfer completes; o_grant_id is valid with it.
- o_err  output  1  one-cycle pulse on illegal mod or start timeout.
- o_err_id  output  ID_W  requester id for o_err.
- o_active  output  1  high from LAUNCH through WAIT_DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE; rr pointer 0; all outputs 0.
- All outputs are registered except o_req_rdy, which is combinational.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE:
  - With i_ser_busy=0, the winner is the first asserted i_req_val at or after the pointer, searching upward and wrapping.
  - o_req_rdy is one-hot on the winner. It is all zeros if no request is pending, i_ser_busy=1, or the state is not IDLE.
  - A handshake captures data, mod and id, and advances the pointer to winner+1 mod N_REQ.
  - If the captured mod is 1 or 2: pulse o_err and o_err_id next cycle, no launch, remain IDLE. Arbitration resumes the following cycle.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - o_ser_val=1 for exactly this cycle; o_ser_data and o_ser_mod hold the captured values; o_active=1.
  - Go to WAIT_START and clear the timeout counter.
- WAIT_START:
  - i_ser_busy=1 -> go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches START_TO: pulse o_err with o_err_id=grant and return to IDLE with no o_done.
- WAIT_DONE: on i_ser_busy falling to 0, pulse o_done with o_grant_id and return to IDLE.
- Latency:
  - Handshake at cycle T -> o_ser_val at T+1.
  - Serializer busy at T+2 for mod=k (0 means 16) -> busy low at T+2+k -> o_done at T+3+k.
  - Next o_req_rdy no earlier than T+3+k.
- o_ser_data and o_ser_mod hold their values after launch until the next capture.
- Simultaneous requests: exactly one is granted per arbitration; the others wait.
  - A requester must hold i_req_val and its data stable until it sees rdy.
  - Dropping val before rdy is legal and simply withdraws the request.
- A requester's own val may be re-asserted immediately after its transfer. It is then lowest priority relative to the others.
- If i_ser_busy=1 while the FSM is in IDLE (external loader), no grant is issued until it clears.
- Reset mid-transfer: the state aborts immediately, o_ser_val drops, and no o_done is produced. The serializer is reset by its own reset.

Test Plan:
1. Single request: req0 val, data 0xA5C3, mod 0 -> rdy[0] same cycle; o_ser_val one cycle later carrying 0xA5C3 and 0; busy 16 cycles; o_done with id 0 once, 3+16 cycles after the handshake.
2. Round-robin: req0..req3 all held with mod 4 -> grants in order 0,1,2,3,0. Each o_done precedes the next rdy. Pointer wrap verified.
3. Illegal mod: req2 mod 1 -> rdy[2]; o_err=1 with o_err_id=2 next cycle; o_ser_val stays 0; pending req3 is granted the following cycle.
4. Timeout: busy tied 0, req1 mod 8 -> o_ser_val pulse; o_err with id 1 exactly START_TO cycles into WAIT_START; no o_done; FSM back in IDLE.
5. Reset mid-transfer: assert i_rst_n=0 during WAIT_DONE of a mod-16 transfer -> all outputs 0 immediately; no o_done; after release, the pointer is 0 and req0 wins over req1.
6. External busy in IDLE: hold i_ser_busy=1 with req0 pending -> rdy stays 0; drop busy -> rdy[0] in the same cycle.
